// File: rtl/fg_opto_conditioner.sv
// Opto input conditioner: synchronises and deglitches the frame-grabber line, strobes
// accepted rising edges, measures rise-to-rise period and flags loss of the signal.
module fg_opto_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 20,
    parameter int TIMEOUT_CYCLES = 8_000_000,
    parameter int CNT_W          = 32
) (
    input  logic             clock,
    input  logic             reset_signal,
    input  logic             fg_opto_raw,
    output logic             fg_opto,
    output logic             fg_opto_rise,
    output logic [CNT_W-1:0] fg_period_cycles,
    output logic             period_valid,
    output logic             fg_lost,
    output logic [1:0]       lock_state
);

    localparam int FILT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PC_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } lock_t;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p1;
    logic [FILT_W-1:0]      filt_cnt;
    logic                   differ;
    logic                   accept;
    logic [CNT_W-1:0]       pc;
    logic                   timeout;
    lock_t                  state_q;
    lock_t                  state_d;
    logic                   capture_en;
    logic                   valid_set;
    logic                   valid_clr;
    logic                   lost_set;

    // Stage p0: metastability chain on the asynchronous pin
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], fg_opto_raw};
        end
    end

    assign s_p1   = sync_p0[SYNC_STAGES-1];
    assign differ = (s_p1 != fg_opto);
    assign accept = differ && (filt_cnt == FILT_LAST);

    // Stage p1: level must disagree for FILTER_CYCLES consecutive cycles to be accepted
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            fg_opto      <= 1'b0;
            fg_opto_rise <= 1'b0;
            filt_cnt     <= '0;
        end else begin
            fg_opto_rise <= accept && s_p1;
            if (!differ) begin
                filt_cnt <= '0;
            end else if (accept) begin
                fg_opto  <= s_p1;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end
    end

    // Stage p2: period counter restarts on each strobe and saturates instead of wrapping
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            pc <= '0;
        end else if (fg_opto_rise) begin
            pc <= '0;
        end else if (pc != PC_MAX) begin
            pc <= pc + CNT_W'(1);
        end
    end

    // A strobe on the same cycle as the timeout wins
    assign timeout = (pc == TO_LAST) && !fg_opto_rise;

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fg_opto_rise) state_d = ARMED;
            ARMED:   if (fg_opto_rise) state_d = LOCKED;
                     else if (timeout) state_d = IDLE;
            LOCKED:  if (timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture_en = fg_opto_rise && (state_q != IDLE);
        valid_set  = fg_opto_rise && (state_q == ARMED);
        valid_clr  = timeout && (state_q == LOCKED);
        lost_set   = timeout && (state_q != IDLE);
    end

    // Period result is kept across a timeout; period_valid marks it stale
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            fg_period_cycles <= '0;
            period_valid     <= 1'b0;
            fg_lost          <= 1'b0;
        end else begin
            if (capture_en) fg_period_cycles <= pc + CNT_W'(1);
            if (valid_set) period_valid <= 1'b1;
            else if (valid_clr) period_valid <= 1'b0;
            if (fg_opto_rise) fg_lost <= 1'b0;
            else if (lost_set) fg_lost <= 1'b1;
        end
    end

    assign lock_state = state_q;

endmodule

// File: tb/tb_fg_opto_conditioner.sv
// Randomised bench for fg_opto_conditioner: a timestamp-based reference model predicts
// every output each cycle; scenario tasks add fixed latency/period/timeout expectations.
module tb_fg_opto_conditioner;

    localparam int SYNC  = 2;
    localparam int FILT  = 20;
    localparam int TOUT  = 3000;
    localparam int CNT_W = 32;
    localparam int OW    = CNT_W + 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             raw = 1'b0;
    logic             fg_opto;
    logic             fg_opto_rise;
    logic [CNT_W-1:0] fg_period_cycles;
    logic             period_valid;
    logic             fg_lost;
    logic [1:0]       lock_state;

    int total = 0;
    int bad   = 0;

    fg_opto_conditioner #(
        .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TOUT), .CNT_W(CNT_W)
    ) dut (
        .clock(clk), .reset_signal(rst), .fg_opto_raw(raw), .fg_opto(fg_opto),
        .fg_opto_rise(fg_opto_rise), .fg_period_cycles(fg_period_cycles),
        .period_valid(period_valid), .fg_lost(fg_lost), .lock_state(lock_state)
    );

    always #5 clk = ~clk;

    // Reference model: delayed pin view, run-length deglitch, strobe timestamps.
    bit         pin_hist[SYNC];
    int         run_len = 0;
    int         cyc = 0;
    int         t_ref = 0;
    int         age;
    bit         s_view;
    bit         new_rise;
    bit         m_opto = 0, m_rise = 0, m_valid = 0, m_lost = 0;
    int         m_state = 0;
    longint     m_period = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) pin_hist[i] = 1'b0;
            run_len = 0; m_opto = 0; m_rise = 0; m_valid = 0; m_lost = 0;
            m_state = 0; m_period = 0; t_ref = cyc;
        end else begin
            s_view = pin_hist[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) pin_hist[i] = pin_hist[i-1];
            pin_hist[0] = raw;
            new_rise = 1'b0;
            if (s_view != m_opto) begin
                run_len++;
                if (run_len == FILT) begin
                    m_opto = s_view; run_len = 0; new_rise = s_view;
                end
            end else begin
                run_len = 0;
            end
            age = cyc - t_ref;
            if (m_rise) begin
                if (m_state == 1) begin m_period = age; m_valid = 1; end
                else if (m_state == 2) m_period = age;
                m_state = (m_state == 0) ? 1 : 2;
                m_lost = 0;
                t_ref = cyc;
            end else if (m_state != 0 && age == TOUT) begin
                m_state = 0; m_lost = 1; m_valid = 0;
            end
            m_rise = new_rise;
        end
        cyc++;
    end

    wire [OW-1:0] obs  = {fg_opto, fg_opto_rise, fg_lost, period_valid, lock_state, fg_period_cycles};
    wire [OW-1:0] expv = {m_opto, m_rise, m_lost, m_valid, m_state[1:0], m_period[CNT_W-1:0]};

    task automatic drive_cycle(input bit v);
        @(posedge clk); #1;
        raw = v;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; raw = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%0h exp=0", obs); end
        total++;
        if (obs !== expv) begin bad++; $display("FAIL reset_model got=%0h exp=%0h", obs, expv); end
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b0);
            total++;
            if (obs !== expv) begin bad++; $display("FAIL reset_idle c=%0d got=%0h exp=%0h", c, obs, expv); end
        end
    endtask

    task automatic test_glitch;
        int w;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 15 : int'($urandom_range(1, FILT - 1));
            for (int c = 0; c < 60; c++) begin
                drive_cycle(c < w);
                total++;
                if (obs !== expv) begin bad++; $display("FAIL glitch_model w=%0d got=%0h exp=%0h", w, obs, expv); end
                total++;
                if (fg_opto !== 1'b0 || fg_opto_rise !== 1'b0) begin
                    bad++; $display("FAIL glitch_level w=%0d got=%b%b exp=00", w, fg_opto, fg_opto_rise);
                end
            end
            total++;
            if (dut.filt_cnt !== '0) begin bad++; $display("FAIL glitch_cnt got=%0d exp=0", dut.filt_cnt); end
        end
    endtask

    task automatic test_latency;
        int first_hi = -1, first_lo = -1, rises = 0, fall_rises = 0;
        for (int c = 0; c < 1060; c++) begin
            drive_cycle(c < 1000);
            total++;
            if (obs !== expv) begin bad++; $display("FAIL latency_model c=%0d got=%0h exp=%0h", c, obs, expv); end
            if (fg_opto && first_hi < 0) first_hi = c;
            if (!fg_opto && c >= 1000 && first_lo < 0) first_lo = c;
            if (fg_opto_rise) begin
                if (c < 1000) rises++; else fall_rises++;
            end
        end
        total++;
        if (first_hi != SYNC + FILT) begin bad++; $display("FAIL latency_rise got=%0d exp=%0d", first_hi, SYNC + FILT); end
        total++;
        if (rises != 1) begin bad++; $display("FAIL latency_strobe got=%0d exp=1", rises); end
        total++;
        if (first_lo != 1000 + SYNC + FILT) begin bad++; $display("FAIL latency_fall got=%0d exp=%0d", first_lo, 1000 + SYNC + FILT); end
        total++;
        if (fall_rises != 0) begin bad++; $display("FAIL latency_fall_strobe got=%0d exp=0", fall_rises); end
    endtask

    task automatic test_period;
        int p, h;
        p = int'($urandom_range(800, 1500));
        h = int'($urandom_range(50, 300));
        @(posedge clk); #1; rst = 1'b1; raw = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 3 * p + 50; c++) begin
            drive_cycle((c < 3 * p) && ((c % p) < h));
            total++;
            if (obs !== expv) begin bad++; $display("FAIL period_model c=%0d got=%0h exp=%0h", c, obs, expv); end
            if (c == SYNC + FILT + 5) begin
                total++;
                if (lock_state !== 2'd1 || period_valid !== 1'b0) begin
                    bad++; $display("FAIL period_armed got=%0d/%b exp=1/0", lock_state, period_valid);
                end
            end
            if (c == p + SYNC + FILT + 5 || c == 3 * p + 49) begin
                total++;
                if (fg_period_cycles !== CNT_W'(p) || period_valid !== 1'b1 || lock_state !== 2'd2) begin
                    bad++; $display("FAIL period_locked c=%0d got=%0d/%b/%0d exp=%0d/1/2", c, fg_period_cycles, period_valid, lock_state, p);
                end
            end
        end
    endtask

    task automatic test_timeout;
        int r = -1, lost_at = -1, c = 0;
        longint stale;
        while (c < TOUT + 300 && lost_at < 0) begin
            drive_cycle(c < 50);
            total++;
            if (obs !== expv) begin bad++; $display("FAIL timeout_model c=%0d got=%0h exp=%0h", c, obs, expv); end
            if (fg_opto_rise) r = c;
            if (fg_lost && lost_at < 0) lost_at = c;
            c++;
        end
        total++;
        if (r < 0 || lost_at - r != TOUT + 1) begin
            bad++; $display("FAIL timeout_delay got=%0d exp=%0d", lost_at - r, TOUT + 1);
        end
        total++;
        if (fg_lost !== 1'b1 || period_valid !== 1'b0 || lock_state !== 2'd0) begin
            bad++; $display("FAIL timeout_flags got=%b/%b/%0d exp=1/0/0", fg_lost, period_valid, lock_state);
        end
        stale = fg_period_cycles;
        for (int k = 0; k < 100; k++) begin
            drive_cycle(1'b1);
            total++;
            if (obs !== expv) begin bad++; $display("FAIL recover_model k=%0d got=%0h exp=%0h", k, obs, expv); end
        end
        total++;
        if (fg_lost !== 1'b0 || lock_state !== 2'd1 || period_valid !== 1'b0 || fg_period_cycles !== stale[CNT_W-1:0]) begin
            bad++; $display("FAIL recover_state got=%b/%0d/%b/%0d exp=0/1/0/%0d", fg_lost, lock_state, period_valid, fg_period_cycles, stale);
        end
    endtask

    task automatic test_toggle;
        int changes = 0;
        logic prev;
        for (int c = 0; c < 40; c++) begin
            drive_cycle(1'b0);
            total++;
            if (obs !== expv) begin bad++; $display("FAIL toggle_settle got=%0h exp=%0h", obs, expv); end
        end
        prev = fg_opto;
        for (int c = 0; c < 1000; c++) begin
            drive_cycle(((c / 10) % 2) == 0);
            total++;
            if (obs !== expv) begin bad++; $display("FAIL toggle_model c=%0d got=%0h exp=%0h", c, obs, expv); end
            if (fg_opto !== prev) changes++;
        end
        total++;
        if (changes != 0 || fg_opto !== 1'b0) begin bad++; $display("FAIL toggle_changes got=%0d exp=0", changes); end
    endtask

    task automatic test_reset_mid;
        int p;
        p = int'($urandom_range(600, 1200));
        for (int c = 0; c < 3 * p + p / 2; c++) begin
            drive_cycle((c % p) < 40);
            total++;
            if (obs !== expv) begin bad++; $display("FAIL mid_model c=%0d got=%0h exp=%0h", c, obs, expv); end
        end
        total++;
        if (lock_state !== 2'd2) begin bad++; $display("FAIL mid_locked got=%0d exp=2", lock_state); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== '0) begin bad++; $display("FAIL mid_reset got=%0h exp=0", obs); end
        for (int c = 0; c < 2 * p; c++) begin
            drive_cycle((c % p) < 40);
            total++;
            if (obs !== expv) begin bad++; $display("FAIL rearm_model c=%0d got=%0h exp=%0h", c, obs, expv); end
            if (c == p - 1) begin
                total++;
                if (lock_state !== 2'd1 || period_valid !== 1'b0) begin
                    bad++; $display("FAIL rearm_first got=%0d/%b exp=1/0", lock_state, period_valid);
                end
            end
        end
        total++;
        if (period_valid !== 1'b1 || fg_period_cycles !== CNT_W'(p) || lock_state !== 2'd2) begin
            bad++; $display("FAIL rearm_second got=%b/%0d/%0d exp=1/%0d/2", period_valid, fg_period_cycles, lock_state, p);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_latency();
        test_period();
        test_timeout();
        test_toggle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
